// File: rtl/imem_load_sequencer_pkg.sv
// Shared definitions for the instruction-memory load sequencer:
// sequencer states, default geometry and the NOP fill word.
package imem_load_sequencer_pkg;

  localparam int          ADDR_W_DEF = 6;
  localparam int          DEPTH_DEF  = 64;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERR   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/imem_load_sequencer_if.sv
// Loader, fetch and memory-port signals of the load sequencer.
// master is the sequencer side, slave is the surrounding system.
interface imem_load_sequencer_if #(
  parameter int ADDR_W = imem_load_sequencer_pkg::ADDR_W_DEF
);

  logic              ld_valid;
  logic [7:0]        ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              reload_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic [31:0]       fetch_inst;
  logic              fetch_valid;
  logic              cpu_stall;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              load_done;
  logic              load_err;

  modport master (
    input  ld_valid, ld_data, ld_last, reload_req, fetch_addr, mem_rdata,
    output ld_ready, fetch_inst, fetch_valid, cpu_stall,
           mem_addr, mem_we, mem_wdata, load_done, load_err
  );

  modport slave (
    output ld_valid, ld_data, ld_last, reload_req, fetch_addr, mem_rdata,
    input  ld_ready, fetch_inst, fetch_valid, cpu_stall,
           mem_addr, mem_we, mem_wdata, load_done, load_err
  );

endinterface

// File: rtl/imem_load_sequencer_byte_packer.sv
// Assembles loader bytes little-endian into a 32-bit word; unfilled
// lanes stay zero because the buffer is cleared after every word.
module imem_load_sequencer_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic        last,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0]  byte_cnt_q;
  logic [31:0] word_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_cnt_q <= '0;
      word_q     <= '0;
    end else if (accept) begin
      word_q[8*byte_cnt_q +: 8] <= data;
      byte_cnt_q                <= byte_cnt_q + 2'd1;
    end
  end

  assign word       = word_q;
  assign word_ready = accept && (last || byte_cnt_q == 2'd3);

endmodule

// File: rtl/imem_load_sequencer.sv
// Boot sequencer owning the instruction-memory port: NOP fill, byte-serial
// image load, then hand-off of the address port to instruction fetch.
module imem_load_sequencer
  import imem_load_sequencer_pkg::*;
#(
  parameter int          ADDR_W    = ADDR_W_DEF,
  parameter int          DEPTH     = DEPTH_DEF,
  parameter logic [31:0] FILL_WORD = NOP_WORD
) (
  input  logic                  clk,
  input  logic                  rst,
  imem_load_sequencer_if.master bus
);

  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic              img_end_q;
  logic              accept;
  logic              packer_clear;
  logic              word_ready;
  logic [31:0]       packed_word;

  assign accept       = bus.ld_valid && (state_q == ST_LOAD);
  assign packer_clear = (state_q == ST_WRITE) || (state_q == ST_CLEAR);

  imem_load_sequencer_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (packer_clear),
    .accept     (accept),
    .last       (bus.ld_last),
    .data       (bus.ld_data),
    .word       (packed_word),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_CLEAR;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (ptr_q == PTR_LAST) state_d = ST_LOAD;
      ST_LOAD:  if (word_ready) state_d = ST_WRITE;
      ST_WRITE: begin
        if (img_end_q)              state_d = ST_RUN;
        else if (ptr_q == PTR_LAST) state_d = ST_ERR;
        else                        state_d = ST_LOAD;
      end
      ST_RUN, ST_ERR: if (bus.reload_req) state_d = ST_CLEAR;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // ptr walks the fill and the load; it only advances in LOAD via WRITE,
  // so an over-long image parks it at the last word and raises ERR.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      img_end_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          ptr_q     <= (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
          img_end_q <= 1'b0;
        end
        ST_LOAD: if (accept && bus.ld_last) img_end_q <= 1'b1;
        ST_WRITE: if (!img_end_q && ptr_q != PTR_LAST) ptr_q <= ptr_q + 1'b1;
        ST_RUN, ST_ERR: if (bus.reload_req) ptr_q <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.ld_ready    = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = ptr_q;
    bus.mem_wdata   = FILL_WORD;
    bus.fetch_inst  = '0;
    bus.fetch_valid = 1'b0;
    bus.cpu_stall   = 1'b1;
    bus.load_done   = 1'b0;
    bus.load_err    = 1'b0;
    case (state_q)
      ST_CLEAR: bus.mem_we = 1'b1;
      ST_LOAD:  bus.ld_ready = 1'b1;
      ST_WRITE: begin
        bus.mem_we    = 1'b1;
        bus.mem_wdata = packed_word;
      end
      ST_RUN: begin
        bus.mem_addr    = bus.fetch_addr;
        bus.fetch_inst  = bus.mem_rdata;
        bus.fetch_valid = 1'b1;
        bus.cpu_stall   = 1'b0;
        bus.load_done   = 1'b1;
      end
      ST_ERR:   bus.load_err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_imem_load_sequencer.sv
// Bench for imem_load_sequencer: behavioural memory, image model built from
// the loader byte stream, directed and randomized load scenarios.
module tb_imem_load_sequencer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] tmem [64];
  logic [31:0] exp_mem [64];

  always #5 clk = ~clk;

  imem_load_sequencer_if #(.ADDR_W(6)) bus ();

  imem_load_sequencer #(.ADDR_W(6), .DEPTH(64), .FILL_WORD(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(posedge clk) if (bus.mem_we === 1'b1) tmem[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = tmem[bus.mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Expected memory image: words packed little-endian from the byte stream,
  // every untouched word holds the NOP fill.
  task automatic build_model(input bit [7:0] q[$]);
    for (int k = 0; k < 64; k++) exp_mem[k] = NOP;
    for (int i = 0; i < q.size(); i++) begin
      if (i % 4 == 0) exp_mem[i / 4] = 32'h0;
      exp_mem[i / 4] = exp_mem[i / 4] | ({24'h0, q[i]} << (8 * (i % 4)));
    end
  endtask

  task automatic check_clear();
    int bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (!(bus.mem_we === 1'b1 && bus.mem_addr === 6'(i) && bus.mem_wdata === NOP &&
            bus.cpu_stall === 1'b1 && bus.ld_ready === 1'b0 && bus.fetch_valid === 1'b0 &&
            bus.fetch_inst === 32'h0 && bus.load_done === 1'b0 && bus.load_err === 1'b0))
        bad++;
    end
    bus.ld_valid = 1'b0;
    chk("clear_sequence_bad_cycles", bad, 0);
    @(negedge clk); #1;
    chk("load_ld_ready", {31'h0, bus.ld_ready}, 1);
    chk("load_mem_we", {31'h0, bus.mem_we}, 0);
  endtask

  task automatic send_byte(input bit [7:0] b, input bit last);
    int n = 0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    bus.ld_valid = 1'b1;
    bus.ld_data  = b;
    bus.ld_last  = last;
    #1;
    while (bus.ld_ready !== 1'b1 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("byte_accepted", {31'h0, bus.ld_ready}, 1);
    @(posedge clk);
    @(negedge clk);
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic send_image(input bit [7:0] q[$], input bit with_last);
    for (int i = 0; i < q.size(); i++) send_byte(q[i], with_last && (i == q.size() - 1));
  endtask

  task automatic finish_image(input int nwords);
    #1;
    chk("final_write_we", {31'h0, bus.mem_we}, 1);
    chk("final_write_addr", {26'h0, bus.mem_addr}, 32'(nwords - 1));
    chk("final_write_data", bus.mem_wdata, exp_mem[nwords - 1]);
    @(negedge clk); #1;
    chk("run_load_done", {31'h0, bus.load_done}, 1);
    chk("run_cpu_stall", {31'h0, bus.cpu_stall}, 0);
    chk("run_fetch_valid", {31'h0, bus.fetch_valid}, 1);
    chk("run_ld_ready", {31'h0, bus.ld_ready}, 0);
  endtask

  task automatic verify_all();
    int bad = 0;
    for (int a = 0; a < 64; a++) begin
      @(negedge clk);
      bus.fetch_addr = 6'(a);
      #1;
      if (bus.fetch_inst !== exp_mem[a] || bus.mem_addr !== 6'(a) || bus.mem_we !== 1'b0) bad++;
    end
    chk("image_readback_bad_words", bad, 0);
  endtask

  task automatic read_word(input string tag, input int a, input logic [31:0] exp);
    @(negedge clk);
    bus.fetch_addr = 6'(a);
    #1;
    chk(tag, bus.fetch_inst, exp);
  endtask

  task automatic do_reload();
    bus.reload_req = 1'b1;
    @(negedge clk);
    bus.reload_req = 1'b0;
    #1;
    chk("reload_cpu_stall", {31'h0, bus.cpu_stall}, 1);
    check_clear();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit [7:0] img[$];
    int       len;

    rst = 1'b1;
    bus.ld_valid = 1'b0; bus.ld_data = 8'h0; bus.ld_last = 1'b0;
    bus.reload_req = 1'b0; bus.fetch_addr = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_mem_we", {31'h0, bus.mem_we}, 1);
    chk("reset_mem_addr", {26'h0, bus.mem_addr}, 0);
    chk("reset_ld_ready", {31'h0, bus.ld_ready}, 0);
    chk("reset_cpu_stall", {31'h0, bus.cpu_stall}, 1);
    chk("reset_fetch_valid", {31'h0, bus.fetch_valid}, 0);
    chk("reset_load_done", {31'h0, bus.load_done}, 0);
    chk("reset_load_err", {31'h0, bus.load_err}, 0);
    rst = 1'b0;
    check_clear();

    // Two-word image.
    img = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00};
    build_model(img);
    send_image(img, 1'b1);
    finish_image(2);
    read_word("word1_fetch", 1, 32'h0050_0113);
    chk("word1_fetch_valid", {31'h0, bus.fetch_valid}, 1);
    read_word("word0_fetch", 0, 32'h0050_0093);
    read_word("word2_nop", 2, NOP);
    verify_all();

    // Reload from RUN with loader already presenting a byte.
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'hEE;
    do_reload();
    img = '{8'h93, 8'h00, 8'h50, 8'h00, 8'hAA};
    build_model(img);
    send_image(img, 1'b1);
    finish_image(2);
    read_word("partial_word1", 1, 32'h0000_00AA);
    read_word("partial_word0", 0, 32'h0050_0093);
    verify_all();

    // Randomized images.
    for (int r = 0; r < 3; r++) begin
      do_reload();
      len = $urandom_range(1, 60);
      img = {};
      for (int i = 0; i < len; i++) img.push_back(8'($urandom));
      build_model(img);
      send_image(img, 1'b1);
      finish_image((len + 3) / 4);
      verify_all();
    end

    // Overflow: 64 full words without last.
    do_reload();
    img = {};
    for (int i = 0; i < 256; i++) img.push_back(8'($urandom));
    send_image(img, 1'b0);
    #1;
    chk("ovf_last_write_addr", {26'h0, bus.mem_addr}, 63);
    chk("ovf_last_write_we", {31'h0, bus.mem_we}, 1);
    @(negedge clk); #1;
    chk("err_load_err", {31'h0, bus.load_err}, 1);
    chk("err_ld_ready", {31'h0, bus.ld_ready}, 0);
    chk("err_cpu_stall", {31'h0, bus.cpu_stall}, 1);
    chk("err_load_done", {31'h0, bus.load_done}, 0);
    chk("err_fetch_valid", {31'h0, bus.fetch_valid}, 0);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'h5A;
    repeat (3) @(negedge clk);
    #1;
    chk("err_holds_load_err", {31'h0, bus.load_err}, 1);
    chk("err_holds_ld_ready", {31'h0, bus.ld_ready}, 0);
    bus.ld_valid = 1'b0;
    do_reload();
    chk("reload_clears_err", {31'h0, bus.load_err}, 0);

    // Reset in the middle of a word.
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midload_rst_addr", {26'h0, bus.mem_addr}, 0);
    check_clear();
    img = '{8'h55};
    build_model(img);
    send_image(img, 1'b1);
    finish_image(1);
    read_word("no_stale_word0", 0, 32'h0000_0055);
    verify_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_load_sequencer.md
Name: imem_load_sequencer

Overview:
- Owns the single address/write port of the 64-word instruction memory.
- Sequences boot: fill all words with NOP, then assemble byte-serial loader data into words and write them sequentially. After that, hands the address port to the IF stage and releases the CPU stall.
- Sits between the IF stage, the external program loader and the instruction memory.
- Supports reload on request and flags loader overflow.

Parameters:
- ADDR_W, 6, word-address width
- DEPTH, 64, number of memory words; must equal 2**ADDR_W
- FILL_WORD, 32'h00000013, value written to every word during clear (addi x0,x0,0)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ld_valid  in  1  loader byte valid
- ld_data  in  8  loader byte
- ld_last  in  1  qualifies the final byte of an image
- ld_ready  out  1  sequencer accepts a byte this cycle
- reload_req  in  1  single-cycle request to reload the image
- fetch_addr  in  ADDR_W  IF-stage word address
- fetch_inst  out  32  instruction to IF stage
- fetch_valid  out  1  fetch_inst is valid (RUN only)
- cpu_stall  out  1  holds the pipeline front end
- mem_addr  out  ADDR_W  memory word address
- mem_we  out  1  memory write enable; write occurs at clk rising edge
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory combinational read data
- load_done  out  1  image loaded, CPU running
- load_err  out  1  image exceeded DEPTH words

Behaviour:
- States: CLEAR, LOAD, WRITE, RUN, ERR. Reset enters CLEAR.
- Reset values: ptr=0, byte_cnt=0, word buffer=0, ld_ready=0, mem_we=1 (CLEAR begins), cpu_stall=1, fetch_valid=0, load_done=0, load_err=0.

CLEAR:
- mem_we=1, mem_addr=ptr, mem_wdata=FILL_WORD; ptr increments each cycle.
- After ptr=DEPTH-1 is written (DEPTH cycles total): ptr←0, go to LOAD.

LOAD:
- ld_ready=1, mem_we=0.
- A byte is accepted when ld_valid&&ld_ready. It goes into word lane byte_cnt, little-endian (first byte → [7:0]); byte_cnt increments mod 4.
- Go to WRITE when the 4th byte is accepted, or when ld_last is accepted.
- On ld_last, lanes above the current byte are zero.

WRITE (exactly 1 cycle):
- ld_ready=0, mem_we=1, mem_addr=ptr, mem_wdata=assembled word; then buffer←0, byte_cnt←0.
- If the image is ended (ld_last was seen): go to RUN.
- Else if ptr=DEPTH-1: go to ERR.
- Else ptr++ and return to LOAD.

RUN:
- mem_addr=fetch_addr, mem_we=0, fetch_inst=mem_rdata (combinational passthrough, zero latency).
- fetch_valid=1, cpu_stall=0, load_done=1, ld_ready=0.

ERR:
- load_err=1, cpu_stall=1, ld_ready=0, mem_we=0. Remains until rst or reload_req.

Outside RUN:
- fetch_inst=0, fetch_valid=0, cpu_stall=1, load_done=0.

reload_req:
- Honoured only in RUN or ERR: next state CLEAR, ptr←0, load_err←0, cpu_stall=1 from the next cycle.
- Ignored in CLEAR/LOAD/WRITE.

Other rules:
- ld_valid outside LOAD is ignored; no data is consumed.
- ld_last with zero prior bytes in the word still writes that word (one byte + zeros).
- Reset mid-LOAD/WRITE discards the partial word and restarts at CLEAR; words already written are overwritten by the fill.
- ptr is ADDR_W bits and never wraps in LOAD; overflow is detected as above.

Decomposition:
- Shared package (imem_pkg): state enum, ADDR_W/DEPTH defaults, NOP_WORD constant 32'h00000013.
- One natural sub-module, byte_packer: byte_cnt plus the 32-bit assembly register, with clear/accept/last inputs and a word_ready output.
- The FSM, ptr and port muxing stay in the top level.

Test Plan:
- Reset, no loader activity → mem_we=1 for 64 cycles at addr 0..63 with data 0x00000013, then ld_ready=1; cpu_stall=1 throughout.
- Bytes 93,00,50,00 then 13,01,50,00 (last on 8th) → word 0=0x00500093, word 1=0x00500113; RUN; fetch_addr=1 gives fetch_inst=0x00500113, fetch_valid=1; word 2 reads 0x00000013.
- 5 bytes 93,00,50,00,AA with last on 5th → word 1=0x000000AA; load_done=1 on the cycle after the WRITE of word 1.
- 64 full words then more bytes without last → after the 64th WRITE, ERR: load_err=1, ld_ready=0, cpu_stall=1; reload_req → CLEAR, load_err=0.
- In RUN, pulse reload_req while ld_valid=1 → cpu_stall=1 next cycle, 64-cycle clear, no byte consumed until LOAD.
- rst asserted after 2 bytes of a word → CLEAR restarts at addr 0; the next loaded word at addr 0 contains no stale bytes.
